// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared types and constants for the two-master memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    function automatic int unsigned wmask_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-input round-robin grant; a tie goes to the side not granted last.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update_en,
    output logic [1:0] o_grant,
    output logic       o_last_grant
);

    logic r_last_grant_q;
    logic w_last_grant_d;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        case (i_req)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = (r_last_grant_q == MST_IFU) ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
        endcase

        w_last_grant_d = r_last_grant_q;
        if (i_update_en && (w_grant != 2'b00)) begin
            w_last_grant_d = w_grant[1] ? MST_LSU : MST_IFU;
        end
    end

    // Reset to LSU so the IFU wins the very first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant_q <= MST_LSU;
        end else begin
            r_last_grant_q <= w_last_grant_d;
        end
    end

    assign o_grant      = w_grant;
    assign o_last_grant = r_last_grant_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : IFU/LSU to single memory port arbiter, one transaction in flight.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            ifu_req_valid,
    output logic                            ifu_req_ready,
    input  logic [ADDR_W-1:0]               ifu_addr,
    output logic                            ifu_resp_valid,
    output logic [DATA_W-1:0]               ifu_rdata,

    input  logic                            lsu_req_valid,
    output logic                            lsu_req_ready,
    input  logic                            lsu_we,
    input  logic [ADDR_W-1:0]               lsu_addr,
    input  logic [DATA_W-1:0]               lsu_wdata,
    input  logic [wmask_width(DATA_W)-1:0]  lsu_wmask,
    output logic                            lsu_resp_valid,
    output logic [DATA_W-1:0]               lsu_rdata,

    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic [wmask_width(DATA_W)-1:0]  mem_wmask,
    input  logic                            mem_resp_valid,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int unsigned c_mask_w = wmask_width(DATA_W);

    arb_state_e            r_state_q, w_state_d;
    logic                  r_owner_q, w_owner_d;
    logic                  r_mem_we_q, w_mem_we_d;
    logic [ADDR_W-1:0]     r_mem_addr_q, w_mem_addr_d;
    logic [DATA_W-1:0]     r_mem_wdata_q, w_mem_wdata_d;
    logic [c_mask_w-1:0]   r_mem_wmask_q, w_mem_wmask_d;

    logic                  w_idle;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_resp_fire;
    logic                  w_last_grant;

    assign w_idle = (r_state_q == ST_IDLE);

    // Requests are only presented to the arbiter in IDLE, so grants are zero elsewhere.
    rr_arb2 u_rr_arb2 (
        .clk          (clk),
        .rst          (rst),
        .i_req        ({lsu_req_valid & w_idle, ifu_req_valid & w_idle}),
        .i_update_en  (w_accept),
        .o_grant      (w_grant),
        .o_last_grant (w_last_grant)
    );

    assign w_accept = w_idle && (w_grant != 2'b00);

    // A response counts only once the request has been handed to memory.
    assign w_resp_fire = mem_resp_valid &&
                         ((r_state_q == ST_RESP) || ((r_state_q == ST_REQ) && mem_req_ready));

    always_comb begin
        w_state_d     = r_state_q;
        w_owner_d     = r_owner_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_mem_wmask_d = r_mem_wmask_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_REQ;
                    if (w_grant[MST_LSU]) begin
                        w_owner_d     = MST_LSU;
                        w_mem_we_d    = lsu_we;
                        w_mem_addr_d  = lsu_addr;
                        w_mem_wdata_d = lsu_wdata;
                        w_mem_wmask_d = lsu_wmask;
                    end else begin
                        w_owner_d     = MST_IFU;
                        w_mem_we_d    = 1'b0;
                        w_mem_addr_d  = ifu_addr;
                        w_mem_wdata_d = '0;
                        w_mem_wmask_d = '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    w_state_d = mem_resp_valid ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_resp_valid) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_owner_q     <= MST_IFU;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_mem_wmask_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_owner_q     <= w_owner_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_mem_wmask_q <= w_mem_wmask_d;
        end
    end

    assign ifu_req_ready  = w_grant[MST_IFU];
    assign lsu_req_ready  = w_grant[MST_LSU];

    assign ifu_resp_valid = w_resp_fire && (r_owner_q == MST_IFU);
    assign lsu_resp_valid = w_resp_fire && (r_owner_q == MST_LSU);
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;

    assign mem_req_valid  = (r_state_q == ST_REQ);
    assign mem_we         = r_mem_we_q;
    assign mem_addr       = r_mem_addr_q;
    assign mem_wdata      = r_mem_wdata_q;
    assign mem_wmask      = r_mem_wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_we         (lsu_we),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = 32'h0;
        lsu_req_valid  = 1'b0;
        lsu_we         = 1'b0;
        lsu_addr       = 32'h0;
        lsu_wdata      = 32'h0;
        lsu_wmask      = 4'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 00000000", mem_wdata); end
        n_checks++; if (mem_wmask !== 4'h0) begin n_fail++; $display("FAIL reset_mem_wmask: got %h expected 0", mem_wmask); end
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 00", {ifu_resp_valid, lsu_resp_valid}); end
        n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready}); end
    endtask

    task automatic test_ifu_single();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL ifu_single_ready: got %b expected 1", ifu_req_ready); end
        n_checks++; if (lsu_req_ready !== 1'b0) begin n_fail++; $display("FAIL ifu_single_lsu_ready: got %b expected 0", lsu_req_ready); end
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'hDEAD_0000;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ifu_single_mem_req_valid: got %b expected 1", mem_req_valid); end
        n_checks++; if (mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL ifu_single_mem_addr: got %h expected 80000000", mem_addr); end
        n_checks++; if ({mem_we, mem_wmask} !== 5'b0) begin n_fail++; $display("FAIL ifu_single_we_wmask: got %b expected 00000", {mem_we, mem_wmask}); end
        n_checks++; if (ifu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_single_early_resp: got %b expected 0", ifu_resp_valid); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0413;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_single_req_drop: got %b expected 0", mem_req_valid); end
        n_checks++; if (ifu_resp_valid !== 1'b1) begin n_fail++; $display("FAIL ifu_single_resp_valid: got %b expected 1", ifu_resp_valid); end
        n_checks++; if (ifu_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL ifu_single_rdata: got %h expected 00000413", ifu_rdata); end
        n_checks++; if (lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_single_lsu_resp: got %b expected 0", lsu_resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (ifu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_single_pulse_end: got %b expected 0", ifu_resp_valid); end
    endtask

    task automatic test_round_robin();
        clear_inputs();
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b0;
        lsu_addr      = 32'h8000_2000;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic        exp_ifu;
            logic [31:0] exp_addr;
            exp_ifu  = (i % 2 == 0);
            exp_addr = exp_ifu ? 32'h8000_0100 : 32'h8000_2000;
            #1;
            n_checks++; if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, ~exp_ifu}) begin n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", i, {ifu_req_ready, lsu_req_ready}, {exp_ifu, ~exp_ifu}); end
            tick();
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'h1000 + i;
            #1;
            n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL rr_mem_addr_%0d: got %h expected %h", i, mem_addr, exp_addr); end
            n_checks++; if ({ifu_resp_valid, lsu_resp_valid} !== {exp_ifu, ~exp_ifu}) begin n_fail++; $display("FAIL rr_resp_route_%0d: got %b expected %b", i, {ifu_resp_valid, lsu_resp_valid}, {exp_ifu, ~exp_ifu}); end
            tick();
            mem_resp_valid = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_store_stall();
        int pulses;
        pulses        = 0;
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 32'h8000_1002;
        lsu_wdata     = 32'h0000_BEEF;
        lsu_wmask     = 4'b1100;
        mem_req_ready = 1'b0;
        #1;
        n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready: got %b expected 1", lsu_req_ready); end
        tick();
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
        lsu_addr      = 32'h1111_1111;
        lsu_wdata     = 32'h2222_2222;
        lsu_wmask     = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h8000_1002, 32'h0000_BEEF, 4'b1100})
                begin n_fail++; $display("FAIL store_stall_hold_%0d: got v=%b we=%b a=%h d=%h m=%b expected v=1 we=1 a=80001002 d=0000beef m=1100", i, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask); end
            if (lsu_resp_valid === 1'b1) pulses++;
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        if (lsu_resp_valid === 1'b1) pulses++;
        tick();
        mem_req_ready = 1'b0;
        #1;
        if (lsu_resp_valid === 1'b1) pulses++;
        tick();
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b01) begin n_fail++; $display("FAIL store_ack: got %b expected 01", {ifu_resp_valid, lsu_resp_valid}); end
        if (lsu_resp_valid === 1'b1) pulses++;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        if (lsu_resp_valid === 1'b1) pulses++;
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL store_ack_count: got %0d expected 1", pulses); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0100;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b expected 1", ifu_req_ready); end
        tick();
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_CAFE;
        #1;
        n_checks++; if ({ifu_resp_valid, ifu_rdata} !== {1'b1, 32'h0000_CAFE}) begin n_fail++; $display("FAIL b2b_same_cycle_resp: got v=%b d=%h expected v=1 d=0000cafe", ifu_resp_valid, ifu_rdata); end
        n_checks++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_no_accept_in_req: got %b expected 0", ifu_req_ready); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        ifu_addr       = 32'h0000_0104;
        #1;
        n_checks++; if ({ifu_req_ready, mem_req_valid} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle_again: got ready,req=%b expected 10", {ifu_req_ready, mem_req_valid}); end
        tick();
        ifu_req_valid  = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if (mem_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 00000104", mem_addr); end
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5A5A_5A5A;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin n_fail++; $display("FAIL spurious_%0d: got resp,req=%b expected 000", i, {ifu_resp_valid, lsu_resp_valid, mem_req_valid}); end
            tick();
        end
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL spurious_still_idle: got %b expected 1", ifu_req_ready); end
        ifu_req_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 32'h8000_3000;
        lsu_wdata     = 32'h1234_5678;
        lsu_wmask     = 4'b1111;
        tick();
        clear_inputs();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst           = 1'b1;
        tick();
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h7777_7777;
        #1;
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_resp: got %b expected 00", {ifu_resp_valid, lsu_resp_valid}); end
        n_checks++; if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask} !== 70'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got v=%b we=%b a=%h d=%h m=%b expected all 0", mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask); end
        tick();
        mem_resp_valid = 1'b0;
        lsu_req_valid  = 1'b1;
        #1;
        n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got %b expected 1", lsu_req_ready); end
        clear_inputs();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_ifu_single();
        test_round_robin();
        test_store_stall();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name:
mem_arbiter

Overview:
- Two-master, one-slave arbiter for the single data memory port. Masters are the IFU (instruction fetch, read-only) and the LSU (loads and stores).
- Round-robin arbitration. Registered request payload. Response routed back to the master that owns the transaction.
- One transaction in flight at a time. Sits between the IFU/LSU and the DPI-backed memory model or bus bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. wmask width is DATA_W/8.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle when valid&&ready
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
ifu_rdata  out  DATA_W  fetch data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted when valid&&ready
lsu_we  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  access address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  byte-enable mask (sb=0001<<off, sh=0011<<off, sw=1111)
lsu_resp_valid  out  1  one-cycle pulse: load data valid, or store acknowledged
lsu_rdata  out  DATA_W  load data; meaningless for stores
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_we  out  1  registered write enable
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered mask; 0 for reads
mem_resp_valid  in  1  memory response pulse; masters always accept it
mem_rdata  in  DATA_W  memory read data

Behaviour:
- States:
  - IDLE: no transaction.
  - REQ: mem_req_valid=1, waiting for mem_req_ready.
  - RESP: waiting for mem_resp_valid.
- Reset:
  - state=IDLE, owner=IFU, last_grant=LSU (so IFU wins the first tie).
  - mem_req_valid=0; mem_we/addr/wdata/wmask=0.
  - ifu_resp_valid=lsu_resp_valid=0.
- Grant (IDLE only, combinational):
  - Only one valid: that master is granted.
  - Both valid: the master that is not last_grant is granted.
  - Only the granted master sees req_ready=1. Both readies are 0 in REQ and RESP.
- Accept (IDLE, granted master valid at cycle T):
  - Latch payload into mem_* registers. IFU payload is forced to we=0, wmask=0.
  - Set owner and last_grant. Move to REQ, so mem_req_valid=1 from T+1.
- REQ:
  - mem_* registers hold stable until mem_req_ready.
  - mem_req_ready=1 and mem_resp_valid=0: go to RESP; mem_req_valid drops next cycle.
  - mem_req_ready=1 and mem_resp_valid=1 in the same cycle: deliver the response that cycle and go to IDLE.
- RESP: on mem_resp_valid, go to IDLE.
- Response routing (combinational):
  - owner_resp_valid = mem_resp_valid && (state==RESP || (state==REQ && mem_req_ready)).
  - ifu_rdata = lsu_rdata = mem_rdata.
- Minimum turnaround: accept at T, response at T+1, next accept at T+2. No back-to-back acceptance.
- mem_resp_valid in IDLE is spurious: dropped, no master pulse, no state change.
- Reset mid-operation: the in-flight transaction is abandoned. Any response arriving after reset is dropped by the IDLE rule.
- Masters must hold request valid and payload until ready. The arbiter does not latch unaccepted requests.
- Address alignment and sign extension are the LSU's job; the arbiter passes data unmodified.

Decomposition:
- Shared package holds the state enum (IDLE/REQ/RESP), master id constants (MST_IFU=0, MST_LSU=1) and the wmask width derivation.
- One natural sub-module: rr_arb2, a two-input round-robin grant with last_grant register and update enable.
- The FSM and payload registers stay in mem_arbiter.

Test Plan:
- Reset, then IFU alone requests 0x80000000; memory ready=1, response one cycle later with 0x00000413 -> ifu_req_ready high at T; mem_req_valid at T+1; mem_addr=0x80000000, mem_wmask=0; ifu_resp_valid pulse with rdata 0x00000413; lsu_resp_valid stays 0.
- IFU and LSU request simultaneously and continuously -> grants alternate IFU, LSU, IFU, LSU; neither master is starved.
- LSU store addr 0x80001002, wdata 0x0000BEEF, wmask 0b1100; memory holds ready low 3 cycles -> mem_* stable through the stall; lsu_resp_valid pulses once on the ack.
- Memory gives ready and resp_valid in the same cycle in REQ -> response delivered that cycle, FSM back to IDLE, next request accepted the following cycle.
- Assert rst while in RESP, then pulse mem_resp_valid after reset -> no resp_valid to either master; state IDLE; outputs at reset values.
- Spurious mem_resp_valid while IDLE with no requests -> no master pulse, no state change.
